// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: turns PS/2 set-2 scan codes into press/release events for an 8-key map,
// tracks held keys and queues events in a 4-deep first-word-fall-through FIFO.
module kbd_event_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] keycodeout,
    input  logic       ev_ready,
    input  logic       ovf_clr,
    output logic       ev_valid,
    output logic       ev_press,
    output logic [2:0] ev_key,
    output logic [7:0] key_state,
    output logic [2:0] ev_count,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t     state_q, state_d;
    logic [7:0] key_state_q, key_state_d;
    logic [3:0] mem_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       ovf_q;

    logic       is_e0, is_f0, complete, make, ext, hit, push, pop, full, wr_en, drop;
    logic [2:0] idx;

    assign is_e0    = keycodeout == 8'hE0;
    assign is_f0    = keycodeout == 8'hF0;
    assign complete = rx_done_tick && !is_e0 && !is_f0;
    assign make     = state_q == IDLE || state_q == EXT;
    assign ext      = state_q == EXT || state_q == EXT_BRK;

    always_comb begin
        hit = 1'b1;
        idx = 3'd0;
        case (keycodeout)
            8'h15:   idx = 3'd0;
            8'h1D:   idx = 3'd1;
            8'h24:   idx = 3'd2;
            8'h5A:   idx = 3'd3;
            8'h75:   idx = 3'd4;
            8'h72:   idx = 3'd5;
            8'h6B:   idx = 3'd6;
            8'h74:   idx = 3'd7;
            default: hit = 1'b0;
        endcase
        if (ext && !idx[2]) hit = 1'b0;
    end

    always_comb begin
        state_d = !rx_done_tick ? state_q
                : is_e0 ? (state_q == IDLE ? EXT : state_q)
                : is_f0 ? (state_q == IDLE ? BRK : state_q == EXT ? EXT_BRK : state_q)
                : IDLE;
    end

    // Only a make on a released key or a break on a held key toggles state and emits an event
    assign push        = complete && hit && (make ? !key_state_q[idx] : key_state_q[idx]);
    assign key_state_d = push ? key_state_q ^ (8'd1 << idx) : key_state_q;
    assign pop         = ev_valid && ev_ready;
    assign full        = count_q == 3'd4;
    assign wr_en       = push && (!full || pop);
    assign drop        = push && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            key_state_q <= 8'h00;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_state_q <= key_state_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {make, idx};
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'd0, wr_en} - {2'd0, pop};
            ovf_q   <= drop || (ovf_q && !ovf_clr);
        end
    end

    assign ev_valid  = count_q != 3'd0;
    assign ev_press  = mem_q[rd_ptr_q][3];
    assign ev_key    = mem_q[rd_ptr_q][2:0];
    assign key_state = key_state_q;
    assign ev_count  = count_q;
    assign overflow  = ovf_q;
endmodule
